// File: rtl/bs_decode.sv
// Receive-side bit unstuffer: drops the 0 inserted after MAX_ONES consecutive 1s,
// flags a stuff error when that bit is a 1, and frames each packet up to eop.
module bs_decode #(
   parameter int PID_BITS = 8,
   parameter int MAX_ONES = 6,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             eop,
   output logic             out_valid,
   output logic             out_bit,
   output logic             stuff_err,
   output logic             pkt_done,
   output logic [CNT_W-1:0] kept_cnt
);

   localparam int PW = $clog2(PID_BITS + 1);
   localparam int OW = $clog2(MAX_ONES + 1);

   localparam logic [PW-1:0] PID_ONE  = PW'(1'b1);
   localparam logic [PW-1:0] PID_LAST = PW'(PID_BITS - 1);
   localparam logic [PW-1:0] PID_ZERO = {PW{1'b0}};
   localparam logic [OW-1:0] RUN_ONE  = OW'(1'b1);
   localparam logic [OW-1:0] RUN_ZERO = {OW{1'b0}};
   localparam logic [OW-1:0] RUN_MAX  = OW'(MAX_ONES);
   localparam bit            PID_SINGLE = (PID_BITS == 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PID   = 3'd1,
      S_COUNT = 3'd2,
      S_DROP  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t          state;
   logic [PW-1:0]   pid_cnt;
   logic [OW-1:0]   ones_cnt;

   logic [OW-1:0]   run_first;
   logic [OW-1:0]   run_next;
   logic [CNT_W-1:0] kept_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_W'(1'b1);
      end
   endfunction

   // Run length after the current bit: first counted bit vs. continuing run.
   always_comb begin
      run_first = RUN_ZERO;
      run_next  = RUN_ZERO;
      if (in_bit) begin
         run_first = RUN_ONE;
         run_next  = ones_cnt + RUN_ONE;
      end else begin
         run_first = RUN_ZERO;
         run_next  = RUN_ZERO;
      end
      kept_inc = sat_inc(kept_cnt);
   end

   // Packet framing FSM with registered outputs; eop has priority over in_valid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         pid_cnt   <= PID_ZERO;
         ones_cnt  <= RUN_ZERO;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         stuff_err <= 1'b0;
         pkt_done  <= 1'b0;
         kept_cnt  <= {CNT_W{1'b0}};
      end else begin
         out_valid <= 1'b0;
         pkt_done  <= 1'b0;
         if (eop) begin
            if (state != S_IDLE) begin
               pkt_done <= 1'b1;
               state    <= S_IDLE;
               ones_cnt <= RUN_ZERO;
               pid_cnt  <= PID_ZERO;
               // The transmitter always sends the stuff bit, so a missing one is an error.
               if (state == S_DROP) begin
                  stuff_err <= 1'b1;
               end
            end
         end else if (in_valid) begin
            case (state)
               S_IDLE: begin
                  stuff_err <= 1'b0;
                  kept_cnt  <= CNT_W'(1'b1);
                  out_valid <= 1'b1;
                  out_bit   <= in_bit;
                  pid_cnt   <= PID_ONE;
                  if (PID_SINGLE) begin
                     ones_cnt <= run_first;
                     state    <= (run_first == RUN_MAX) ? S_DROP : S_COUNT;
                  end else begin
                     state    <= S_PID;
                  end
               end
               S_PID: begin
                  kept_cnt  <= kept_inc;
                  out_valid <= 1'b1;
                  out_bit   <= in_bit;
                  pid_cnt   <= pid_cnt + PID_ONE;
                  // Only the last PID bit seeds the run of 1s.
                  if (pid_cnt == PID_LAST) begin
                     ones_cnt <= run_first;
                     state    <= (run_first == RUN_MAX) ? S_DROP : S_COUNT;
                  end
               end
               S_COUNT: begin
                  kept_cnt  <= kept_inc;
                  out_valid <= 1'b1;
                  out_bit   <= in_bit;
                  ones_cnt  <= run_next;
                  if (run_next == RUN_MAX) begin
                     state <= S_DROP;
                  end
               end
               S_DROP: begin
                  if (in_bit) begin
                     stuff_err <= 1'b1;
                     state     <= S_ERROR;
                  end else begin
                     ones_cnt  <= RUN_ZERO;
                     state     <= S_COUNT;
                  end
               end
               S_ERROR: begin
                  state <= S_ERROR;
               end
               default: begin
                  state    <= S_IDLE;
                  pid_cnt  <= PID_ZERO;
                  ones_cnt <= RUN_ZERO;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bs_decode.sv
// Self-checking bench for bs_decode: directed framing/error cases plus random
// packets produced by a behavioural transmit-stuffer model.
module tb_bs_decode;

   localparam int PID_BITS = 8;
   localparam int MAX_ONES = 6;
   localparam int CNT_W    = 16;

   typedef bit bq_t[$];

   logic             clock;
   logic             reset;
   logic             in_valid;
   logic             in_bit;
   logic             eop;
   logic             out_valid;
   logic             out_bit;
   logic             stuff_err;
   logic             pkt_done;
   logic [CNT_W-1:0] kept_cnt;

   int checks = 0;
   int errors = 0;

   bs_decode #(.PID_BITS(PID_BITS), .MAX_ONES(MAX_ONES), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .eop(eop),
      .out_valid(out_valid), .out_bit(out_bit), .stuff_err(stuff_err),
      .pkt_done(pkt_done), .kept_cnt(kept_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Transmit stuffer: runs count from the last PID bit; a 0 follows every run of MAX_ONES.
   function automatic void stuff_stream(input bq_t raw, output bq_t tx, output bq_t is_stuff);
      int run;
      run = 0;
      tx = {};
      is_stuff = {};
      for (int i = 0; i < raw.size(); i++) begin
         tx.push_back(raw[i]);
         is_stuff.push_back(1'b0);
         if (i >= PID_BITS - 1) begin
            run = raw[i] ? run + 1 : 0;
            if (run == MAX_ONES) begin
               tx.push_back(1'b0);
               is_stuff.push_back(1'b1);
               run = 0;
            end
         end
      end
   endfunction

   function automatic bq_t byte_bits(input logic [7:0] v);
      bq_t q;
      q = {};
      for (int i = 0; i < 8; i++) q.push_back(v[i]);
      return q;
   endfunction

   function automatic bit same_q(input bq_t a, input bq_t b);
      if (a.size() != b.size()) return 1'b0;
      for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic step(input logic v, input logic b, input logic e);
      @(negedge clock);
      in_valid = v;
      in_bit   = b;
      eop      = e;
      @(posedge clock);
      #1;
   endtask

   task automatic send_bits(input bq_t bits, output bq_t got);
      got = {};
      for (int i = 0; i < bits.size(); i++) begin
         step(1'b1, bits[i], 1'b0);
         if (out_valid) got.push_back(out_bit);
      end
   endtask

   task automatic end_packet(output int pulses);
      pulses = 0;
      step(1'b0, 1'b0, 1'b1);
      pulses += int'(pkt_done);
      step(1'b0, 1'b0, 1'b0);
      pulses += int'(pkt_done);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; eop = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({out_valid, out_bit, stuff_err, pkt_done} !== 4'b0000 || kept_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: got ov=%b ob=%b err=%b done=%b kept=%0d, want all 0",
                  out_valid, out_bit, stuff_err, pkt_done, kept_cnt);
      end
      @(negedge clock);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (pkt_done !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_eop_ignored: got done=%b ov=%b, want 0 0", pkt_done, out_valid);
      end
   endtask

   task automatic test_pid_a5();
      bq_t stim, exp, got;
      int pulses;
      stim = byte_bits(8'hA5);
      exp  = stim;
      repeat (5) begin stim.push_back(1'b1); exp.push_back(1'b1); end
      stim.push_back(1'b0);
      stim.push_back(1'b1);
      exp.push_back(1'b1);
      send_bits(stim, got);
      end_packet(pulses);
      checks++;
      if (!same_q(got, exp)) begin
         errors++;
         $display("FAIL a5_stream: got %p, want %p", got, exp);
      end
      checks++;
      if (kept_cnt !== 16'd14 || stuff_err !== 1'b0 || pulses !== 1) begin
         errors++;
         $display("FAIL a5_status: got kept=%0d err=%b pulses=%0d, want 14 0 1",
                  kept_cnt, stuff_err, pulses);
      end
   endtask

   task automatic test_pid_ff();
      bq_t stim, exp, got;
      int pulses;
      stim = byte_bits(8'hFF);
      exp  = stim;
      repeat (5) begin stim.push_back(1'b1); exp.push_back(1'b1); end
      stim.push_back(1'b0);
      stim.push_back(1'b0);
      exp.push_back(1'b0);
      send_bits(stim, got);
      end_packet(pulses);
      checks++;
      if (!same_q(got, exp)) begin
         errors++;
         $display("FAIL ff_stream: got %p, want %p", got, exp);
      end
      checks++;
      if (kept_cnt !== 16'd14 || stuff_err !== 1'b0 || pulses !== 1) begin
         errors++;
         $display("FAIL ff_status: got kept=%0d err=%b pulses=%0d, want 14 0 1",
                  kept_cnt, stuff_err, pulses);
      end
   endtask

   task automatic test_stuff_error();
      bq_t stim, got;
      int pulses;
      int late_valid;
      stim = byte_bits(8'h2D);
      repeat (6) stim.push_back(1'b1);
      send_bits(stim, got);
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (stuff_err !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL err_on_7th: got err=%b ov=%b, want 1 0", stuff_err, out_valid);
      end
      late_valid = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'(i & 1), 1'b0);
         late_valid += int'(out_valid);
      end
      end_packet(pulses);
      checks++;
      if (late_valid !== 0 || pulses !== 1 || kept_cnt !== 16'd14 || stuff_err !== 1'b1) begin
         errors++;
         $display("FAIL err_hold: got late_valid=%0d pulses=%0d kept=%0d err=%b, want 0 1 14 1",
                  late_valid, pulses, kept_cnt, stuff_err);
      end
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (stuff_err !== 1'b0 || kept_cnt !== 16'd1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL err_clear: got err=%b kept=%0d ov=%b, want 0 1 1",
                  stuff_err, kept_cnt, out_valid);
      end
      end_packet(pulses);
   endtask

   task automatic test_eop_in_drop();
      bq_t stim, got;
      int pulses;
      stim = byte_bits(8'hC3);
      repeat (5) stim.push_back(1'b1);
      send_bits(stim, got);
      end_packet(pulses);
      checks++;
      if (stuff_err !== 1'b1 || pulses !== 1 || kept_cnt !== 16'd13 || got.size() !== 13) begin
         errors++;
         $display("FAIL eop_in_drop: got err=%b pulses=%0d kept=%0d fwd=%0d, want 1 1 13 13",
                  stuff_err, pulses, kept_cnt, got.size());
      end
   endtask

   task automatic test_random_gaps();
      bq_t raw, tx, is_stuff;
      int pulses;
      for (int p = 0; p < 2; p++) begin
         raw = {};
         for (int i = 0; i < 200; i++) raw.push_back(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         stuff_stream(raw, tx, is_stuff);
         for (int i = 0; i < tx.size(); i++) begin
            for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
               step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
               checks++;
               if (out_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL gap_valid: pkt %0d bit %0d got ov=%b, want 0", p, i, out_valid);
               end
            end
            step(1'b1, tx[i], 1'b0);
            checks++;
            if (out_valid !== !is_stuff[i] || (!is_stuff[i] && out_bit !== tx[i])) begin
               errors++;
               $display("FAIL rand_bit: pkt %0d bit %0d got ov=%b ob=%b, want ov=%b ob=%b",
                        p, i, out_valid, out_bit, !is_stuff[i], tx[i]);
            end
         end
         end_packet(pulses);
         checks++;
         if (kept_cnt !== 16'd200 || stuff_err !== 1'b0 || pulses !== 1) begin
            errors++;
            $display("FAIL rand_status: pkt %0d got kept=%0d err=%b pulses=%0d, want 200 0 1",
                     p, kept_cnt, stuff_err, pulses);
         end
      end
   endtask

   task automatic test_back_to_back();
      bq_t raw, tx, is_stuff;
      int fwd;
      for (int p = 0; p < 3; p++) begin
         raw = {};
         for (int i = 0; i < 40 + p * 10; i++) raw.push_back(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
         stuff_stream(raw, tx, is_stuff);
         fwd = 0;
         for (int i = 0; i < tx.size(); i++) begin
            step(1'b1, tx[i], 1'b0);
            if (i == 0) begin
               checks++;
               if (pkt_done !== 1'b0 || stuff_err !== 1'b0 || kept_cnt !== 16'd1) begin
                  errors++;
                  $display("FAIL b2b_start: pkt %0d got done=%b err=%b kept=%0d, want 0 0 1",
                           p, pkt_done, stuff_err, kept_cnt);
               end
            end
            if (out_valid && out_bit === tx[i] && !is_stuff[i]) fwd++;
         end
         step(1'b1, 1'b1, 1'b1);
         checks++;
         if (pkt_done !== 1'b1 || out_valid !== 1'b0 || fwd !== raw.size() ||
             kept_cnt !== 16'(raw.size())) begin
            errors++;
            $display("FAIL b2b_end: pkt %0d got done=%b ov=%b fwd=%0d kept=%0d, want 1 0 %0d %0d",
                     p, pkt_done, out_valid, fwd, kept_cnt, raw.size(), raw.size());
         end
      end
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_in_drop();
      bq_t stim, got;
      int pulses;
      stim = byte_bits(8'h00);
      repeat (6) stim.push_back(1'b1);
      send_bits(stim, got);
      @(negedge clock);
      in_valid = 1'b0; eop = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if ({out_valid, out_bit, stuff_err, pkt_done} !== 4'b0000 || kept_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_in_drop: got ov=%b ob=%b err=%b done=%b kept=%0d, want all 0",
                  out_valid, out_bit, stuff_err, pkt_done, kept_cnt);
      end
      @(negedge clock);
      reset = 1'b0;
      stim = byte_bits(8'h5A);
      stim.push_back(1'b1);
      stim.push_back(1'b0);
      send_bits(stim, got);
      end_packet(pulses);
      checks++;
      if (!same_q(got, stim) || kept_cnt !== 16'd10 || stuff_err !== 1'b0 || pulses !== 1) begin
         errors++;
         $display("FAIL fresh_after_reset: got %p kept=%0d err=%b pulses=%0d, want %p 10 0 1",
                  got, kept_cnt, stuff_err, pulses, stim);
      end
   endtask

   initial begin
      test_reset();
      test_pid_a5();
      test_pid_ff();
      test_stuff_error();
      test_eop_in_drop();
      test_random_gaps();
      test_back_to_back();
      test_reset_in_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
